memory_bus_arbiter: RTL and testbench

//  N-master to 1-slave concentrator for the packet memory bus (ms/sm channels, Valid/Taken handshake).

---
 rtl/memory_bus_arbiter_pkg.sv | 30 +++
 rtl/memory_bus_arbiter_rr_arbiter.sv | 42 ++++
 rtl/memory_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared definitions for the packet memory bus: ID width helpers and the request payload layout.
package memory_bus_pkg;

  localparam int DEF_MASTER_ID_W = 8;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_MASTERS     = 4;

  // Bits needed to carry a port index; never below 1 so slices stay legal.
  function automatic int port_bits(input int n);
    int b;
    b = 1;
    while ((1 << b) < n) b++;
    return b;
  endfunction

  function automatic int dn_id_width(input int master_id_w, input int n);
    return master_id_w + port_bits(n);
  endfunction

  localparam int DEF_DN_ID_W = dn_id_width(DEF_MASTER_ID_W, DEF_MASTERS);

  typedef struct packed {
    logic [DEF_DN_ID_W-1:0] id;
    logic [DEF_ADDR_W-1:0]  address;
    logic [DEF_DATA_W-1:0]  data;
    logic                   write;
  } mem_req_t;

endpackage

// File: rtl/memory_bus_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
module rr_arbiter
  import memory_bus_pkg::*;
#(
  parameter int  N  = 4,
  localparam int PB = port_bits(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PB-1:0] idx,
  output logic          any
);

  logic [PB-1:0] ptr;

  always_comb begin
    int k;
    k     = 0;
    any   = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any = 1'b1;
        idx = PB'(k);
      end
    end
    grant = (en && any) ? (N'(1) << idx) : '0;
  end

  // Pointer starts at the last port so port 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= PB'(N - 1);
    else if (en && any)
      ptr <= idx;
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// N-master to 1-slave memory bus concentrator with round-robin request stage and ID-routed responses.
// Define MEMORY_BUS_ARB_RESP_BUF_EN to register the response path (1-cycle latency).
module memory_bus_arbiter
  import memory_bus_pkg::*;
#(
  parameter int  NUM_MASTERS     = 4,
  parameter int  MASTER_ID_WIDTH = 8,
  parameter int  ADDRESS_WIDTH   = 32,
  parameter int  DATA_WIDTH      = 16,
  localparam int PORT_BITS       = port_bits(NUM_MASTERS),
  localparam int DN_ID_W         = MASTER_ID_WIDTH + PORT_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_MASTERS*MASTER_ID_WIDTH-1:0] upMsID,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] upMsAddress,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    upMsData,
  input  logic [NUM_MASTERS-1:0]               upMsWrite,
  input  logic [NUM_MASTERS-1:0]               upMsValid,
  output logic [NUM_MASTERS-1:0]               upMsTaken,
  output logic [NUM_MASTERS*MASTER_ID_WIDTH-1:0] upSmID,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]    upSmData,
  output logic [NUM_MASTERS-1:0]               upSmValid,
  input  logic [NUM_MASTERS-1:0]               upSmTaken,
  output logic [DN_ID_W-1:0]                   dnMsID,
  output logic [ADDRESS_WIDTH-1:0]             dnMsAddress,
  output logic [DATA_WIDTH-1:0]                dnMsData,
  output logic                                 dnMsWrite,
  output logic                                 dnMsValid,
  input  logic                                 dnMsTaken,
  input  logic [DN_ID_W-1:0]                   dnSmID,
  input  logic [DATA_WIDTH-1:0]                dnSmData,
  input  logic                                 dnSmValid,
  output logic                                 dnSmTaken,
  output logic                                 errBadID
);

  typedef struct packed {
    logic [DN_ID_W-1:0]       id;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    data;
    logic                     write;
  } req_t;

  logic                 load;
  logic [PORT_BITS-1:0] gnt_idx;
  logic                 gnt_any;
  req_t                 req_p0;
  req_t                 req_p1;
  logic                 vld_p1;

  // Reset also blocks the combinational Taken so no master sees an acceptance while in reset.
  assign load = !rst && (!vld_p1 || dnMsTaken);

  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (upMsValid),
    .en    (load),
    .grant (upMsTaken),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_comb begin
    req_p0.id      = {gnt_idx, upMsID[int'(gnt_idx)*MASTER_ID_WIDTH +: MASTER_ID_WIDTH]};
    req_p0.address = upMsAddress[int'(gnt_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    req_p0.data    = upMsData[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    req_p0.write   = upMsWrite[gnt_idx];
  end

  // p0 -> p1: request output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      req_p1 <= '0;
    end else if (load) begin
      vld_p1 <= gnt_any;
      if (gnt_any)
        req_p1 <= req_p0;
    end
  end

  assign dnMsValid   = vld_p1;
  assign dnMsID      = req_p1.id;
  assign dnMsAddress = req_p1.address;
  assign dnMsData    = req_p1.data;
  assign dnMsWrite   = req_p1.write;

  logic [PORT_BITS-1:0] sm_port;
  logic [31:0]          sm_port_ext;
  logic                 sm_bad;

  assign sm_port     = dnSmID[DN_ID_W-1 -: PORT_BITS];
  assign sm_port_ext = 32'(sm_port);
  assign sm_bad      = sm_port_ext >= 32'(NUM_MASTERS);

`ifdef MEMORY_BUS_ARB_RESP_BUF_EN
  logic                       rsp_vld_p1;
  logic [PORT_BITS-1:0]       rsp_port_p1;
  logic [MASTER_ID_WIDTH-1:0] rsp_id_p1;
  logic [DATA_WIDTH-1:0]      rsp_data_p1;
  logic [NUM_MASTERS-1:0]     rsp_sel;
  logic                       rsp_load;
  logic                       rsp_accept;

  assign rsp_sel    = NUM_MASTERS'(1) << rsp_port_p1;
  assign rsp_load   = !rsp_vld_p1 || (|(upSmTaken & rsp_sel));
  assign rsp_accept = dnSmValid && !sm_bad;
  assign dnSmTaken  = rsp_load;

  // p0 -> p1: response buffer; bad IDs are consumed here and never stored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld_p1  <= 1'b0;
      rsp_port_p1 <= '0;
      rsp_id_p1   <= '0;
      rsp_data_p1 <= '0;
    end else if (rsp_load) begin
      rsp_vld_p1 <= rsp_accept;
      if (rsp_accept) begin
        rsp_port_p1 <= sm_port;
        rsp_id_p1   <= dnSmID[MASTER_ID_WIDTH-1:0];
        rsp_data_p1 <= dnSmData;
      end
    end
  end

  assign upSmValid = rsp_vld_p1 ? rsp_sel : '0;
  assign upSmID    = {NUM_MASTERS{rsp_id_p1}};
  assign upSmData  = {NUM_MASTERS{rsp_data_p1}};
`else
  assign upSmValid = (dnSmValid && !sm_bad) ? (NUM_MASTERS'(1) << sm_port) : '0;
  assign dnSmTaken = sm_bad || (|(upSmTaken & (NUM_MASTERS'(1) << sm_port)));
  assign upSmID    = {NUM_MASTERS{dnSmID[MASTER_ID_WIDTH-1:0]}};
  assign upSmData  = {NUM_MASTERS{dnSmData}};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      errBadID <= 1'b0;
    else if (dnSmValid && sm_bad && dnSmTaken)
      errBadID <= 1'b1;
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: a 4-port instance plus a 3-port instance for bad-ID routing.
module tb_memory_bus_arbiter;

  localparam int N   = 4;
  localparam int MID = 8;
  localparam int AW  = 32;
  localparam int DW  = 16;
  localparam int DIW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*MID-1:0] upMsID;
  logic [N*AW-1:0]  upMsAddress;
  logic [N*DW-1:0]  upMsData;
  logic [N-1:0]     upMsWrite, upMsValid, upMsTaken;
  logic [N*MID-1:0] upSmID;
  logic [N*DW-1:0]  upSmData;
  logic [N-1:0]     upSmValid, upSmTaken;
  logic [DIW-1:0]   dnMsID, dnSmID;
  logic [AW-1:0]    dnMsAddress;
  logic [DW-1:0]    dnMsData, dnSmData;
  logic             dnMsWrite, dnMsValid, dnMsTaken, dnSmValid, dnSmTaken, errBadID;

  logic [3*MID-1:0] upMsID3;
  logic [3*AW-1:0]  upMsAddress3;
  logic [3*DW-1:0]  upMsData3;
  logic [2:0]       upMsWrite3, upMsValid3, upMsTaken3;
  logic [3*MID-1:0] upSmID3;
  logic [3*DW-1:0]  upSmData3;
  logic [2:0]       upSmValid3, upSmTaken3;
  logic [DIW-1:0]   dnMsID3, dnSmID3;
  logic [AW-1:0]    dnMsAddress3;
  logic [DW-1:0]    dnMsData3, dnSmData3;
  logic             dnMsWrite3, dnMsValid3, dnMsTaken3, dnSmValid3, dnSmTaken3, errBadID3;
  logic             unused_tb;

  assign unused_tb = ^{upSmID3, upSmData3, upSmID[15:0], upSmData[47:0]};

  memory_bus_arbiter #(.NUM_MASTERS(N), .MASTER_ID_WIDTH(MID), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .upMsID(upMsID), .upMsAddress(upMsAddress), .upMsData(upMsData), .upMsWrite(upMsWrite),
    .upMsValid(upMsValid), .upMsTaken(upMsTaken),
    .upSmID(upSmID), .upSmData(upSmData), .upSmValid(upSmValid), .upSmTaken(upSmTaken),
    .dnMsID(dnMsID), .dnMsAddress(dnMsAddress), .dnMsData(dnMsData), .dnMsWrite(dnMsWrite),
    .dnMsValid(dnMsValid), .dnMsTaken(dnMsTaken),
    .dnSmID(dnSmID), .dnSmData(dnSmData), .dnSmValid(dnSmValid), .dnSmTaken(dnSmTaken),
    .errBadID(errBadID)
  );

  memory_bus_arbiter #(.NUM_MASTERS(3), .MASTER_ID_WIDTH(MID), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut3 (
    .clk(clk), .rst(rst),
    .upMsID(upMsID3), .upMsAddress(upMsAddress3), .upMsData(upMsData3), .upMsWrite(upMsWrite3),
    .upMsValid(upMsValid3), .upMsTaken(upMsTaken3),
    .upSmID(upSmID3), .upSmData(upSmData3), .upSmValid(upSmValid3), .upSmTaken(upSmTaken3),
    .dnMsID(dnMsID3), .dnMsAddress(dnMsAddress3), .dnMsData(dnMsData3), .dnMsWrite(dnMsWrite3),
    .dnMsValid(dnMsValid3), .dnMsTaken(dnMsTaken3),
    .dnSmID(dnSmID3), .dnSmData(dnSmData3), .dnSmValid(dnSmValid3), .dnSmTaken(dnSmTaken3),
    .errBadID(errBadID3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    upMsID = '0; upMsAddress = '0; upMsData = '0; upMsWrite = '0; upMsValid = '0;
    upSmTaken = '0; dnMsTaken = 1'b0; dnSmID = '0; dnSmData = '0; dnSmValid = 1'b0;
    upMsID3 = '0; upMsAddress3 = '0; upMsData3 = '0; upMsWrite3 = '0; upMsValid3 = '0;
    upSmTaken3 = '0; dnMsTaken3 = 1'b0; dnSmID3 = '0; dnSmData3 = '0; dnSmValid3 = 1'b0;
    tick();
    tick();
    chk("rst_dn_valid", 32'(dnMsValid), 0);
    chk("rst_up_taken", 32'(upMsTaken), 0);
    chk("rst_err", 32'(errBadID), 0);
    chk("rst_dn_addr", dnMsAddress, 0);
    rst = 1'b0;

    // Single request from port 2
    upMsValid = 4'b0100;
    upMsID[2*MID +: MID] = 8'h5A;
    upMsAddress[2*AW +: AW] = 32'h100;
    upMsData[2*DW +: DW] = 16'hCAFE;
    upMsWrite = 4'b0100;
    dnMsTaken = 1'b1;
    #1;
    chk("sp_taken", 32'(upMsTaken), 32'h4);
    tick();
    upMsValid = '0;
    upMsWrite = '0;
    #1;
    chk("sp_dn_valid", 32'(dnMsValid), 1);
    chk("sp_dn_id", 32'(dnMsID), 32'h25A);
    chk("sp_dn_addr", dnMsAddress, 32'h100);
    chk("sp_dn_data", 32'(dnMsData), 32'hCAFE);
    chk("sp_dn_write", 32'(dnMsWrite), 1);
    tick();
    chk("sp_drain", 32'(dnMsValid), 0);

    // Response routed to port 3
    dnSmValid = 1'b1;
    dnSmID = 10'h311;
    dnSmData = 16'hBEEF;
    upSmTaken = '0;
    #1;
`ifdef MEMORY_BUS_ARB_RESP_BUF_EN
    chk("rsp_lat1_valid", 32'(upSmValid), 0);
    chk("rsp_lat1_taken", 32'(dnSmTaken), 1);
    tick();
    dnSmValid = 1'b0;
    #1;
`endif
    chk("rsp_valid", 32'(upSmValid), 32'h8);
    chk("rsp_id", 32'(upSmID[3*MID +: MID]), 32'h11);
    chk("rsp_data", 32'(upSmData[3*DW +: DW]), 32'hBEEF);
    chk("rsp_stall", 32'(dnSmTaken), 0);
    upSmTaken = 4'b1000;
    #1;
    chk("rsp_release", 32'(dnSmTaken), 1);
    tick();
    dnSmValid = 1'b0;
    upSmTaken = '0;
    #1;
    chk("rsp_done", 32'(upSmValid), 0);

    // Bad port index on the 3-port instance
    dnSmValid3 = 1'b1;
    dnSmID3 = 10'h377;
    dnSmData3 = 16'h1234;
    #1;
    chk("bad_taken", 32'(dnSmTaken3), 1);
    chk("bad_no_valid", 32'(upSmValid3), 0);
    tick();
    dnSmValid3 = 1'b0;
    #1;
    chk("bad_err", 32'(errBadID3), 1);
    chk("bad_no_valid2", 32'(upSmValid3), 0);
    tick();
    tick();
    chk("bad_err_sticky", 32'(errBadID3), 1);
    chk("good_err_clear", 32'(errBadID), 0);

    // Reset asserted while a request is held
    for (int p = 0; p < N; p++) begin
      upMsID[p*MID +: MID] = 8'(8'h10 + p);
      upMsAddress[p*AW +: AW] = 32'(32'h1000 + p);
    end
    upMsValid = 4'b1111;
    dnMsTaken = 1'b1;
    tick();
    chk("pre_rst_valid", 32'(dnMsValid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dn_valid", 32'(dnMsValid), 0);
    chk("arst_up_taken", 32'(upMsTaken), 0);
    chk("arst_err", 32'(errBadID3), 0);
    chk("d3_req_idle", 32'({dnMsValid3, |dnMsID3, |dnMsAddress3, |dnMsData3, dnMsWrite3, |upMsTaken3}), 0);
    tick();
    rst = 1'b0;

    // Fairness with all ports requesting
    for (int i = 0; i < 6; i++) begin
      logic [1:0] g;
      g = 2'(i % N);
      #1;
      chk($sformatf("rr_grant%0d", i), 32'(upMsTaken), 32'(1) << g);
      tick();
      chk($sformatf("rr_valid%0d", i), 32'(dnMsValid), 1);
      chk($sformatf("rr_id%0d", i), 32'(dnMsID), 32'({g, 8'(8'h10 + g)}));
    end

    // Backpressure holds the stage with port 1's request
    dnMsTaken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_taken%0d", i), 32'(upMsTaken), 0);
      chk($sformatf("bp_valid%0d", i), 32'(dnMsValid), 1);
      chk($sformatf("bp_id%0d", i), 32'(dnMsID), 32'h111);
      chk($sformatf("bp_addr%0d", i), dnMsAddress, 32'h1001);
      tick();
    end
    dnMsTaken = 1'b1;
    #1;
    chk("bp_next_grant", 32'(upMsTaken), 32'h4);
    tick();
    chk("bp_next_id", 32'(dnMsID), 32'h212);
    upMsValid = '0;
    tick();
    chk("final_idle", 32'(dnMsValid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
